// File: rtl/lut_sweep.sv
// Loadable N-input truth table with single-shot evaluation and a full
// minterm sweep that also counts the true minterms.
module lut_sweep #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_valid,
  input  logic         load_bit,
  output logic         load_ready,
  input  logic         eval_valid,
  input  logic [N-1:0] eval_in,
  input  logic         start,
  output logic         s,
  output logic         s_valid,
  output logic [N-1:0] idx,
  output logic         busy,
  output logic         table_ready,
  output logic         done,
  output logic [N:0]   ones_count
);

  localparam int T = 1 << N;
  localparam logic [N-1:0] K_LAST = N'(T - 1);
  localparam logic [N-1:0] K_ONE  = N'(1);

  typedef enum logic [1:0] {EMPTY, LOAD, READY, SWEEP} state_t;

  state_t         state_q, state_d;
  logic [T-1:0]   table_q, table_d;
  logic [N-1:0]   k_q, k_d;
  logic           s_q, s_d;
  logic           s_valid_q, s_valid_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           done_q, done_d;
  logic           table_ready_q, table_ready_d;
  logic [N:0]     ones_q, ones_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load_valid) state_d = LOAD;
      LOAD:  if (load_valid && (k_q == K_LAST)) state_d = READY;
      READY: begin
        if (start)           state_d = SWEEP;
        else if (load_valid) state_d = LOAD;
      end
      SWEEP: if (k_q == K_LAST) state_d = READY;
      default: state_d = EMPTY;
    endcase
  end

  // Sweep entry already emits minterm 0 so results start one cycle after start.
  always_comb begin
    table_d       = table_q;
    k_d           = k_q;
    s_d           = s_q;
    idx_d         = idx_q;
    s_valid_d     = 1'b0;
    done_d        = 1'b0;
    table_ready_d = table_ready_q;
    ones_d        = ones_q;
    unique case (state_q)
      EMPTY: begin
        if (load_valid) begin
          table_d[0]    = load_bit;
          k_d           = K_ONE;
          table_ready_d = 1'b0;
        end
      end
      LOAD: begin
        if (load_valid) begin
          table_d[k_q] = load_bit;
          if (k_q == K_LAST) begin
            k_d           = '0;
            table_ready_d = 1'b1;
          end else begin
            k_d = k_q + K_ONE;
          end
        end
      end
      READY: begin
        if (start) begin
          s_d       = table_q[0];
          idx_d     = '0;
          s_valid_d = 1'b1;
          ones_d    = (N+1)'(table_q[0]);
          k_d       = K_ONE;
        end else if (load_valid) begin
          table_d[0]    = load_bit;
          k_d           = K_ONE;
          table_ready_d = 1'b0;
        end else if (eval_valid) begin
          s_d       = table_q[eval_in];
          idx_d     = eval_in;
          s_valid_d = 1'b1;
        end
      end
      SWEEP: begin
        s_d       = table_q[k_q];
        idx_d     = k_q;
        s_valid_d = 1'b1;
        ones_d    = ones_q + (N+1)'(table_q[k_q]);
        if (k_q == K_LAST) begin
          k_d    = '0;
          done_d = 1'b1;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      table_q       <= '0;
      k_q           <= '0;
      s_q           <= 1'b0;
      s_valid_q     <= 1'b0;
      idx_q         <= '0;
      done_q        <= 1'b0;
      table_ready_q <= 1'b0;
      ones_q        <= '0;
    end else begin
      table_q       <= table_d;
      k_q           <= k_d;
      s_q           <= s_d;
      s_valid_q     <= s_valid_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      table_ready_q <= table_ready_d;
      ones_q        <= ones_d;
    end
  end

  always_comb begin
    busy       = (state_q == LOAD) || (state_q == SWEEP);
    load_ready = (state_q != SWEEP);
  end

  assign s           = s_q;
  assign s_valid     = s_valid_q;
  assign idx         = idx_q;
  assign done        = done_q;
  assign table_ready = table_ready_q;
  assign ones_count  = ones_q;

endmodule

// File: tb/tb_lut_sweep.sv
// Directed bench for lut_sweep: N=3 load/eval/sweep/reset scenarios and an
// N=6 all-ones sweep.
module tb_lut_sweep;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       load_valid = 1'b0, load_bit = 1'b0, eval_valid = 1'b0, start = 1'b0;
  logic [2:0] eval_in = '0;
  logic       load_ready, s, s_valid, busy, table_ready, done;
  logic [2:0] idx;
  logic [3:0] ones_count;

  logic       load_valid6 = 1'b0, load_bit6 = 1'b0, eval_valid6 = 1'b0, start6 = 1'b0;
  logic [5:0] eval_in6 = '0;
  logic       load_ready6, s6, s_valid6, busy6, table_ready6, done6;
  logic [5:0] idx6;
  logic [6:0] ones_count6;

  int total = 0;
  int bad = 0;

  localparam logic [7:0] TBL_A = 8'b1110_0100;
  localparam logic [7:0] TBL_B = 8'b0000_0001;
  localparam logic [7:0] TBL_C = 8'b0000_1111;

  always #5 clk = ~clk;

  lut_sweep #(.N(3)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_bit(load_bit),
    .load_ready(load_ready), .eval_valid(eval_valid), .eval_in(eval_in),
    .start(start), .s(s), .s_valid(s_valid), .idx(idx), .busy(busy),
    .table_ready(table_ready), .done(done), .ones_count(ones_count)
  );

  lut_sweep #(.N(6)) dut6 (
    .clk(clk), .reset(reset), .load_valid(load_valid6), .load_bit(load_bit6),
    .load_ready(load_ready6), .eval_valid(eval_valid6), .eval_in(eval_in6),
    .start(start6), .s(s6), .s_valid(s_valid6), .idx(idx6), .busy(busy6),
    .table_ready(table_ready6), .done(done6), .ones_count(ones_count6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " s"}, 32'(s), 0);
    checkOutput({tag, " s_valid"}, 32'(s_valid), 0);
    checkOutput({tag, " idx"}, 32'(idx), 0);
    checkOutput({tag, " done"}, 32'(done), 0);
    checkOutput({tag, " busy"}, 32'(busy), 0);
    checkOutput({tag, " table_ready"}, 32'(table_ready), 0);
    checkOutput({tag, " ones_count"}, 32'(ones_count), 0);
    checkOutput({tag, " load_ready"}, 32'(load_ready), 1);
  endtask

  // Gap cycles follow the 1,0,1,1,0 pattern and carry start/eval noise.
  task automatic loadTable(input logic [7:0] tbl, input bit gaps);
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int i = 0;
    int p = 0;
    while (i < 8) begin
      if (gaps && !pat[p % 5]) begin
        load_valid = 1'b0;
        start      = 1'b1;
        eval_valid = 1'b1;
        eval_in    = 3'(i);
        tick();
        checkOutput("gap s_valid", 32'(s_valid), 0);
        checkOutput("gap busy", 32'(busy), 1);
      end else begin
        load_valid = 1'b1;
        load_bit   = tbl[i];
        start      = 1'b0;
        eval_valid = 1'b0;
        tick();
        checkOutput("load busy", 32'(busy), (i != 7) ? 1 : 0);
        checkOutput("load table_ready", 32'(table_ready), (i == 7) ? 1 : 0);
        checkOutput("load load_ready", 32'(load_ready), 1);
        checkOutput("load s_valid", 32'(s_valid), 0);
        i++;
      end
      p++;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    eval_valid = 1'b0;
  endtask

  task automatic checkSweep(input logic [7:0] tbl, input int ones,
                            input bit withEval, input bit withLoad);
    start      = 1'b1;
    eval_valid = withEval;
    eval_in    = 3'b101;
    tick();
    start      = 1'b0;
    eval_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        load_valid = withLoad && (k < 7);
        load_bit   = 1'b1;
        tick();
      end
      checkOutput("sweep s_valid", 32'(s_valid), 1);
      checkOutput("sweep s", 32'(s), 32'(tbl[k]));
      checkOutput("sweep idx", 32'(idx), 32'(k));
      checkOutput("sweep done", 32'(done), (k == 7) ? 1 : 0);
      checkOutput("sweep busy", 32'(busy), (k == 7) ? 0 : 1);
      checkOutput("sweep load_ready", 32'(load_ready), (k == 7) ? 1 : 0);
    end
    load_valid = 1'b0;
    checkOutput("sweep ones_count", 32'(ones_count), 32'(ones));
    tick();
    checkOutput("post s_valid", 32'(s_valid), 0);
    checkOutput("post done", 32'(done), 0);
    checkOutput("post s hold", 32'(s), 32'(tbl[7]));
    checkOutput("post idx hold", 32'(idx), 7);
    checkOutput("post ones hold", 32'(ones_count), 32'(ones));
    checkOutput("post table_ready", 32'(table_ready), 1);
  endtask

  task automatic applyStimulus();
    int nres;
    bit seen;

    repeat (2) tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();
    checkResetValues("idle");

    $display("[TB] gap-free load and sweep");
    loadTable(TBL_A, 1'b0);
    checkSweep(TBL_A, 4, 1'b0, 1'b0);

    $display("[TB] single evaluations");
    eval_valid = 1'b1;
    eval_in    = 3'b101;
    tick();
    checkOutput("eval5 s_valid", 32'(s_valid), 1);
    checkOutput("eval5 s", 32'(s), 1);
    checkOutput("eval5 idx", 32'(idx), 5);
    eval_in = 3'b011;
    tick();
    checkOutput("eval3 s_valid", 32'(s_valid), 1);
    checkOutput("eval3 s", 32'(s), 0);
    checkOutput("eval3 idx", 32'(idx), 3);
    eval_valid = 1'b0;
    tick();
    checkOutput("eval idle s_valid", 32'(s_valid), 0);
    checkOutput("eval hold idx", 32'(idx), 3);
    checkOutput("eval hold ones", 32'(ones_count), 4);

    $display("[TB] reload, start+eval collision, load during sweep");
    loadTable(TBL_B, 1'b0);
    checkSweep(TBL_B, 1, 1'b1, 1'b1);

    $display("[TB] gapped load");
    loadTable(TBL_A, 1'b1);
    checkSweep(TBL_A, 4, 1'b0, 1'b0);

    $display("[TB] reset mid-sweep");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("pre-abort idx", 32'(idx), 4);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    tick();
    reset = 1'b0;
    start      = 1'b1;
    eval_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("after abort s_valid", 32'(s_valid), 0);
      checkOutput("after abort done", 32'(done), 0);
      checkOutput("after abort busy", 32'(busy), 0);
      checkOutput("after abort table_ready", 32'(table_ready), 0);
    end
    start      = 1'b0;
    eval_valid = 1'b0;
    loadTable(TBL_C, 1'b0);
    checkSweep(TBL_C, 4, 1'b0, 1'b0);

    $display("[TB] N=6 all-ones sweep");
    for (int i = 0; i < 64; i++) begin
      load_valid6 = 1'b1;
      load_bit6   = 1'b1;
      tick();
    end
    load_valid6 = 1'b0;
    checkOutput("n6 table_ready", 32'(table_ready6), 1);
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    nres = 0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (s_valid6) nres++;
      if (done6) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("n6 done seen", 32'(seen), 1);
    checkOutput("n6 result count", 32'(nres), 64);
    checkOutput("n6 ones_count", 32'(ones_count6), 64);
    checkOutput("n6 last idx", 32'(idx6), 63);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lut_sweep.md
LUT_SWEEP -- requirements
Module: lut_sweep

Interface
REQ-001 Parameter N, default 3, SHALL set the number of function inputs; legal range 1..6; truth table size T = 2^N bits.
REQ-002 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset SHALL force all state immediately, independent of clk.
REQ-004 load_valid  input  1  table bit offered this cycle.
REQ-005 load_bit  input  1  truth-table bit value; bits SHALL arrive in minterm index order 0..T-1.
REQ-006 load_ready  output  1  1 when a table bit can be accepted.
REQ-007 eval_valid  input  1  single-evaluation request.
REQ-008 eval_in  input  N  input combination to evaluate; eval_in[N-1] is the MSB (x of x,y,z).
REQ-009 start  input  1  sweep request: evaluate all T combinations.
REQ-010 s  output  1  registered function result.
REQ-011 s_valid  output  1  s and idx valid this cycle.
REQ-012 idx  output  N  input combination that produced s.
REQ-013 busy  output  1  1 while loading or sweeping.
REQ-014 table_ready  output  1  1 when a complete table is held.
REQ-015 done  output  1  one-cycle pulse after the last sweep result.
REQ-016 ones_count  output  N+1  number of true minterms counted by the last completed sweep.

Function
REQ-017 FSM states SHALL be EMPTY, LOAD, READY, SWEEP.
REQ-018 Transfer rule: a table bit is accepted on a rising edge where load_valid=1 and load_ready=1; load_ready SHALL be 1 in EMPTY, LOAD and READY, and 0 in SWEEP.
REQ-019 A transfer in EMPTY or READY SHALL write table[0], clear table_ready, and enter LOAD with the write index set to 1.
REQ-020 In LOAD, each transfer SHALL write table[k] and increment k; the transfer that writes table[T-1] SHALL enter READY, wrap k to 0 and set table_ready=1.
REQ-021 In LOAD, cycles with load_valid=0 SHALL hold k and the partial table; eval_valid and start SHALL be ignored.
REQ-022 In READY, eval_valid=1 SHALL produce s=table[eval_in], idx=eval_in and s_valid=1 on the next cycle (latency 1); s_valid SHALL be 0 otherwise.
REQ-023 In READY, start=1 SHALL enter SWEEP.
REQ-024 In SWEEP, the block SHALL emit s=table[k], idx=k and s_valid=1 for k=0..T-1 on T consecutive cycles; the first result appears one cycle after start is sampled.
REQ-025 ones_count SHALL be cleared on sweep entry, SHALL accumulate each emitted s, and SHALL be final when done pulses; its width N+1 holds T without overflow.
REQ-026 After the result for k=T-1, the block SHALL return to READY and pulse done=1 for exactly one cycle, coincident with that last s_valid.
REQ-027 busy SHALL be 1 in LOAD and SWEEP and 0 in EMPTY and READY.
REQ-028 Priority in READY SHALL be: start first, then load_valid, then eval_valid; lower-priority requests in the same cycle are dropped, not queued.
REQ-029 start and eval_valid in EMPTY, LOAD or SWEEP SHALL be ignored; load_valid in SWEEP SHALL be ignored.
REQ-030 s, idx and ones_count SHALL hold their last values when s_valid=0.

Reset
REQ-031 Reset SHALL set state=EMPTY, table to all zeros, k=0, s=0, s_valid=0, idx=0, done=0, busy=0, table_ready=0, ones_count=0 and load_ready=1.
REQ-032 Reset asserted mid-LOAD or mid-SWEEP SHALL abort the operation immediately; no further s_valid or done is produced and the partial table is discarded.
REQ-033 The first transfer after reset release SHALL write table[0].

Verification
REQ-034 N=3, load bits 0,0,1,0,0,1,1,1 on 8 consecutive cycles -> table_ready=1 after the 8th transfer, busy back to 0, load_ready stays 1.
REQ-035 Same table, start -> s sequence 0,0,1,0,0,1,1,1 with idx 0..7 on 8 consecutive cycles, done coincident with idx=7, ones_count=4.
REQ-036 Same table, eval_valid with eval_in=3'b101 -> next cycle s=1, idx=5, s_valid=1; then eval_in=3'b011 -> s=0, idx=3.
REQ-037 Load with load_valid gaps (pattern 1,0,1,1,0,...) -> table identical to the gap-free load; start and eval_valid during the load produce no s_valid.
REQ-038 Reset asserted at sweep idx=4 -> all outputs take their reset values immediately, table_ready=0, no done; a new load then restarts at table[0].
REQ-039 In READY, start and eval_valid in the same cycle -> sweep runs and the eval is dropped; all-ones table with N=6 -> ones_count=64.
